// File: rtl/nfca_pkg.sv
// Shared definitions for the NFC-A front end.
// Contents:
//   - Frame timing constants for the AD7276 serial reader.
//   - Reader FSM state encoding.
//   - Helper functions that slice a captured 16-bit ADC frame.
`timescale 1ns/1ps
package nfca_pkg;

  // An ADC frame has 32 clk of active SCLK and 4 clk of quiet time.
  // 36 clk equals 6 carrier periods, which keeps sampling phase-locked.
  localparam int FRAME_CONV_LEN = 32;
  localparam int FRAME_LEN      = 36;
  // Frame bit numbers, counted from the first bit shifted out (bit 0).
  localparam int DATA_MSB_BIT   = 2;
  localparam int DATA_LSB_BIT   = 13;

  localparam int FRAME_BITS     = 16;
  localparam int CNT_W          = 6;
  localparam int ADC_W          = DATA_LSB_BIT - DATA_MSB_BIT + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_QUIET = 2'd2
  } adc_state_t;

  // Frame bit b sits at sr[FRAME_BITS-1-b] because bits are shifted in MSB first.
  function automatic logic [ADC_W-1:0] frame_data(input logic [FRAME_BITS-1:0] sr);
    return sr[FRAME_BITS-1-DATA_MSB_BIT -: ADC_W];
  endfunction

  // The AD7276 pads each sample with two leading and two trailing zeros.
  // Any of those four bits being set means the frame was mis-aligned.
  function automatic logic frame_err(input logic [FRAME_BITS-1:0] sr);
    return (|sr[FRAME_BITS-1 -: DATA_MSB_BIT]) |
           (|sr[FRAME_BITS-2-DATA_LSB_BIT:0]);
  endfunction

endpackage

// File: rtl/ad7276_reader.sv
// AD7276 continuous-conversion reader.
// A 36-clk frame is generated. Within it, CSN is low for 32 clk, and SCLK
// runs at half the system clock during that window. The 16 returned bits are
// captured on each SCLK rising edge. One sample is presented every frame.
// Ports:
//   clk, rstn     : system clock, asynchronous active-low reset
//   en            : level enable; a started frame always completes
//   ad7276_csn    : registered ADC chip select (active low)
//   ad7276_sclk   : registered ADC serial clock (idles high)
//   ad7276_sdata  : ADC serial data in, MSB first
//   adc_data_en   : one-cycle strobe, issued at frame count 33
//   adc_data      : 12-bit unsigned sample, held between strobes
//   adc_err       : frame padding error, qualified by adc_data_en
//   dbg_state     : current FSM state (observability)
//   dbg_cnt       : current frame counter (observability)
// Handshake: adc_data_en is a valid-only strobe with no ready/back-pressure.
// adc_data and adc_err are meaningful in the cycle where adc_data_en=1.
// The consumer must take the sample in that cycle.
`timescale 1ns/1ps
module ad7276_reader
  import nfca_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  output logic              ad7276_csn,
  output logic              ad7276_sclk,
  input  logic              ad7276_sdata,
  output logic              adc_data_en,
  output logic [ADC_W-1:0]  adc_data,
  output logic              adc_err,
  output adc_state_t        dbg_state,
  output logic [CNT_W-1:0]  dbg_cnt
);

  localparam logic [CNT_W-1:0] CNT_CONV_LAST  = CNT_W'(FRAME_CONV_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_CONV_END   = CNT_W'(FRAME_CONV_LEN);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  adc_state_t             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sdata;
  logic [FRAME_BITS-1:0]  r_sr;

  adc_state_t             w_next_state;
  logic [CNT_W-1:0]       w_next_cnt;
  logic                   w_next_csn;
  logic                   w_next_sclk;
  logic                   w_shift;
  logic                   w_frame_done;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = '0;
        if (en) w_next_state = ST_CONV;
      end
      ST_CONV: begin
        w_next_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_CONV_LAST) w_next_state = ST_QUIET;
      end
      ST_QUIET: begin
        // en is only consulted at the end of the quiet time.
        // This prevents the quiet time from being shortened.
        if (r_cnt == CNT_FRAME_LAST) begin
          w_next_cnt   = '0;
          w_next_state = en ? ST_CONV : ST_IDLE;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase

    // The pins are registered from the next state/count.
    // This keeps them aligned with r_state/r_cnt.
    w_next_csn  = (w_next_state != ST_CONV);
    w_next_sclk = (w_next_state != ST_CONV) || !w_next_cnt[0];

    // Bit k is in r_sdata during count 2k+1. It is taken on the edge into
    // count 2k+2, which is the SCLK rising edge.
    w_shift      = (r_state == ST_CONV) && r_cnt[0];
    w_frame_done = (r_state == ST_QUIET) && (r_cnt == CNT_CONV_END);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sdata     <= 1'b0;
      r_sr        <= '0;
      ad7276_csn  <= 1'b1;
      ad7276_sclk <= 1'b1;
      adc_data_en <= 1'b0;
      adc_data    <= '0;
      adc_err     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_sdata     <= ad7276_sdata;
      ad7276_csn  <= w_next_csn;
      ad7276_sclk <= w_next_sclk;
      adc_data_en <= w_frame_done;
      if (w_shift) r_sr <= {r_sr[FRAME_BITS-2:0], r_sdata};
      if (w_frame_done) begin
        adc_data <= frame_data(r_sr);
        adc_err  <= frame_err(r_sr);
      end
    end
  end

  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_ad7276_reader.sv
`timescale 1ns/1ps
module tb_ad7276_reader;
  import nfca_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic en = 1'b0;
  logic sdata = 1'b0;
  always #6.145 clk = ~clk;   // 81.36 MHz

  logic        csn, sclk, data_en, err;
  logic [11:0] data;
  adc_state_t  dbg_state;
  logic [5:0]  dbg_cnt;

  ad7276_reader dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .ad7276_csn   (csn),
    .ad7276_sclk  (sclk),
    .ad7276_sdata (sdata),
    .adc_data_en  (data_en),
    .adc_data     (data),
    .adc_err      (err),
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [12:0] exp_q[$];     // {err, data}
  logic [15:0] model_q[$];   // raw 16-bit frames the ADC model will send

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // word: the raw frame; exp_data/exp_err: hand-derived result; expect_pulse: frame should complete
  task automatic queue_frame(input logic [15:0] word, input logic [11:0] exp_data,
                             input logic exp_err, input bit expect_pulse);
    model_q.push_back(word);
    if (expect_pulse) exp_q.push_back({exp_err, exp_data});
  endtask

  // ---------------- behavioural AD7276 ----------------
  initial begin : adc_model
    logic [15:0] word;
    forever begin
      @(negedge csn);
      word = (model_q.size() > 0) ? model_q.pop_front() : 16'h0000;
      #8 sdata = word[15];
      for (int k = 1; k < 16; k++) begin
        @(negedge sclk or posedge csn);
        if (csn) break;
        #8 sdata = word[15-k];
      end
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = -1;
  logic chk_spacing = 1'b0;
  logic prev_csn = 1'b1, prev_sclk = 1'b1;
  logic in_frame = 1'b0, seen_high = 1'b0;
  int   frame_cyc = 0, falls = 0, high_cnt = 0, pulses_in_frame = 0;
  logic [12:0] e_item;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      prev_csn = 1'b1; prev_sclk = 1'b1; in_frame = 1'b0; seen_high = 1'b0;
      frame_cyc = 0; falls = 0; high_cnt = 0; pulses_in_frame = 0;
    end else begin
      if (prev_csn && !csn) begin
        if (seen_high) check("csn_high_ge4", int'(high_cnt >= 4), 1);
        in_frame = 1'b1; falls = 0; frame_cyc = 0; pulses_in_frame = 0;
      end else begin
        frame_cyc++;
      end
      if (!csn && prev_sclk && !sclk) falls++;
      if (!prev_csn && csn && in_frame) begin
        check("sclk_falls", falls, 16);
        seen_high = 1'b1; high_cnt = 0;
      end
      if (csn) high_cnt++;
      if (data_en) begin
        pulse_cnt++; pulses_in_frame++;
        check("pulse_pos", frame_cyc, 33);
        check("pulse_once", pulses_in_frame, 1);
        if (chk_spacing && last_pulse_cyc >= 0) check("pulse_period", cyc - last_pulse_cyc, 36);
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", 1, 0);
        end else begin
          e_item = exp_q.pop_front();
          check("adc_data", int'(data), int'(e_item[11:0]));
          check("adc_err", int'(err), int'(e_item[12]));
        end
      end
      prev_csn = csn; prev_sclk = sclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, int'(exp_q.size() == 0), 1);
    en = 1'b0;
  endtask

  task automatic wait_csn_fall(input string name);
    int n = 0;
    while (csn !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_csn_fell"}, int'(csn === 1'b0), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int p0;
    int low_cycles;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csn", int'(csn), 1);
    check("rst_sclk", int'(sclk), 1);
    check("rst_data_en", int'(data_en), 0);
    check("rst_data", int'(data), 0);
    check("rst_err", int'(err), 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_csn", int'(csn), 1);

    // A: repeated 12'hABC, continuous
    for (int i = 0; i < 3; i++) queue_frame(16'h2AF0, 12'hABC, 1'b0, 1'b1);
    last_pulse_cyc = -1; chk_spacing = 1'b1;
    en = 1'b1;
    wait_drain("abc");
    chk_spacing = 1'b0;
    repeat (40) @(negedge clk);

    // B: extremes
    queue_frame(16'h0000, 12'h000, 1'b0, 1'b1);
    queue_frame(16'h3FFC, 12'hFFF, 1'b0, 1'b1);
    last_pulse_cyc = -1; chk_spacing = 1'b1;
    en = 1'b1;
    wait_drain("extremes");
    chk_spacing = 1'b0;
    repeat (40) @(negedge clk);

    // C: padding errors on isolated frames
    queue_frame(16'h2AF0, 12'hABC, 1'b0, 1'b1);
    queue_frame(16'h5694, 12'h5A5, 1'b1, 1'b1);  // leading bit 1 set
    queue_frame(16'h048C, 12'h123, 1'b0, 1'b1);
    queue_frame(16'h2AF1, 12'hABC, 1'b1, 1'b1);  // trailing bit 15 set
    queue_frame(16'h0000, 12'h000, 1'b0, 1'b1);
    last_pulse_cyc = -1; chk_spacing = 1'b1;
    en = 1'b1;
    wait_drain("errflag");
    chk_spacing = 1'b0;
    repeat (40) @(negedge clk);

    // D: en dropped at cnt=10, frame must complete and then stay idle
    queue_frame(16'h0F1C, 12'h3C7, 1'b0, 1'b1);
    en = 1'b1;
    wait_csn_fall("endrop");
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_drain("endrop");
    low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!csn || !sclk) low_cycles++;
    end
    check("endrop_idle_pins", low_cycles, 0);

    // E: reset at cnt=20 discards the frame
    queue_frame(16'h1DDC, 12'h777, 1'b0, 1'b0);
    en = 1'b1;
    wait_csn_fall("midrst");
    repeat (20) @(negedge clk);
    p0 = pulse_cnt;
    rstn = 1'b0;
    en = 1'b0;
    #1;
    check("midrst_csn", int'(csn), 1);
    check("midrst_sclk", int'(sclk), 1);
    check("midrst_data", int'(data), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_data_en", int'(data_en), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    check("midrst_no_pulse", pulse_cnt - p0, 0);

    // F: first frame starts one cycle after en is sampled
    queue_frame(16'h03C0, 12'h0F0, 1'b0, 1'b1);
    @(negedge clk);
    check("start_pre_csn", int'(csn), 1);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("start_csn_low", int'(csn), 0);
    wait_drain("start");
    repeat (50) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ad7276_reader.md
AD7276_READER -- requirements
Module: ad7276_reader

Interface
REQ-001 rstn  input  1  asynchronous active-low reset.
REQ-002 clk  input  1  81.36 MHz system clock; all logic in this single domain.
REQ-003 en  input  1  continuous-conversion enable; level-sensitive.
REQ-004 ad7276_csn  output  1  ADC chip select, active low, registered.
REQ-005 ad7276_sclk  output  1  ADC serial clock, registered, idles high.
REQ-006 ad7276_sdata  input  1  ADC serial data, MSB first.
REQ-007 adc_data_en  output  1  one-cycle pulse; adc_data and adc_err valid.
REQ-008 adc_data  output  12  last converted sample, unsigned, held between pulses.
REQ-009 adc_err  output  1  frame-format error flag for the current sample, qualified by adc_data_en.

Function
REQ-010 The block SHALL register ad7276_sdata once (sdata_r) before any use.
REQ-011 The block SHALL run a 3-state FSM: IDLE, CONV, QUIET, with a 6-bit frame counter cnt.
REQ-012 In IDLE: csn=1, sclk=1, cnt=0; en=1 -> CONV on the next edge with cnt=0.
REQ-013 In CONV, cnt SHALL count 0..31; csn=0; sclk=0 when cnt odd, sclk=1 when cnt even, giving 16 SCLK periods at 40.68 MHz.
REQ-014 At cnt=31 the FSM SHALL go to QUIET at cnt=32.
REQ-015 In QUIET, cnt SHALL count 32..35 with csn=1 and sclk=1, giving a 4-cycle quiet time.
REQ-016 At cnt=35, en=1 -> CONV with cnt=0; en=0 -> IDLE.
REQ-017 Frame period SHALL be 36 clk, which is 6 carrier periods: 2.26 MSPS, phase-locked to the carrier divider.
REQ-018 A 16-bit shift register SHALL capture sdata_r at cnt = 2,4,...,32 (bit k at cnt=2k+2, k=0..15), shifting MSB first.
REQ-019 adc_data SHALL be set to frame bits 2..13 (bit 2 = MSB), and adc_data_en SHALL pulse high, on the cycle with cnt=33.
REQ-020 adc_err SHALL be 1 if any of frame bits 0, 1, 14 or 15 is nonzero, and 0 otherwise.
REQ-021 en falling mid-frame SHALL NOT abort the frame; the frame completes, its pulse is issued, then the FSM goes to IDLE.
REQ-022 en rising during QUIET SHALL take effect only at cnt=35, with no shortened quiet time.
REQ-023 adc_data_en SHALL never pulse outside cnt=33, and at most once per frame.

Reset
REQ-024 On rstn=0, immediately and asynchronously: state=IDLE, cnt=0, csn=1, sclk=1, adc_data_en=0, adc_data=0, adc_err=0, shift register=0, sdata_r=0.
REQ-025 A reset mid-frame SHALL discard the partial frame, with no pulse.
REQ-026 After rstn rises, the first CONV SHALL start one cycle after en is sampled high.

Structure
REQ-027 FRAME_CONV_LEN=32, FRAME_LEN=36, DATA_MSB_BIT=2, DATA_LSB_BIT=13 and the state enum SHALL live in the shared nfca package.
REQ-028 No sub-module; a single flat module (about 150 lines).
REQ-029 The instantiating system top SHALL connect the ADC pins directly to this block and feed adc_data/adc_data_en to the RX demodulator.

Verification
REQ-030 The bench SHALL use a behavioural AD7276 model that drives bit 0 on the csn fall and each subsequent bit after each sclk fall, with 8 ns delay.
REQ-031 Sample 12'hABC, en=1 -> adc_data=12'hABC and adc_err=0, pulsing at cnt=33 of each frame, every 36 clk.
REQ-032 Samples 12'h000 then 12'hFFF -> adc_data=000 then FFF, adc_err=0 both.
REQ-033 Model forces leading bit 1 = 1 -> adc_err=1 on that frame only.
REQ-034 en dropped at cnt=10 -> the frame completes, exactly one pulse, then csn stays 1 and sclk stays 1.
REQ-035 rstn asserted at cnt=20 -> csn=1 and sclk=1 within the same cycle, no pulse, adc_data=0.
REQ-036 Count sclk falls per csn-low window = 16 exactly, and csn-high time ≥ 4 clk, on every frame.
